// File: rtl/div_period_monitor.sv
// div_period_monitor: watches the clock divider's output, counts its rising
// edges, measures rise-to-rise period in clk cycles and flags a stall when
// no edge arrives within TIMEOUT cycles.
//
// Output protocol: period_valid_o is a one-cycle strobe with no backpressure.
// period_o is stable from that strobe until the next one. rise_pulse_o leads
// period_valid_o by exactly one cycle.
module div_period_monitor #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable_i,
    input  logic             div_in_i,
    output logic             rise_pulse_o,
    output logic [CNT_W-1:0] period_o,
    output logic             period_valid_o,
    output logic [CNT_W-1:0] edge_count_o,
    output logic             stall_o,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] GAP_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    state_t             state_q, state_d;
    logic               s0_q, s1_q;
    logic [CNT_W-1:0]   gap_q, gap_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic [CNT_W-1:0]   edge_q, edge_d;
    logic               pv_q, pv_d;
    logic               stall_q, stall_d;
    logic               rise;

    // Rising edge of the synchronised divider output.
    assign rise = s0_q & ~s1_q;

    assign rise_pulse_o   = rise & (state_q != IDLE);
    assign period_o       = period_q;
    assign period_valid_o = pv_q;
    assign edge_count_o   = edge_q;
    assign stall_o        = stall_q;
    assign state_o        = state_q;

    // Two-flop synchroniser on div_in plus all measurement state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s0_q     <= 1'b0;
            s1_q     <= 1'b0;
            gap_q    <= '0;
            period_q <= '0;
            edge_q   <= '0;
            pv_q     <= 1'b0;
            stall_q  <= 1'b0;
            state_q  <= IDLE;
        end else begin
            s0_q     <= div_in_i;
            s1_q     <= s0_q;
            gap_q    <= gap_d;
            period_q <= period_d;
            edge_q   <= edge_d;
            pv_q     <= pv_d;
            stall_q  <= stall_d;
            state_q  <= state_d;
        end
    end

    // Next-state logic: a rise beats a coincident timeout, and disabling
    // beats everything (a rise seen while enable is low is dropped).
    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        period_d = period_q;
        edge_d   = edge_q;
        pv_d     = 1'b0;
        stall_d  = stall_q;

        if (!enable_i) begin
            state_d = IDLE;
            gap_d   = '0;
            stall_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    gap_d   = '0;
                    stall_d = 1'b0;
                    state_d = ARM;
                end
                ARM, MEASURE: begin
                    if (rise) begin
                        // ARM has no previous edge, so no period is formed.
                        if (state_q == MEASURE) begin
                            period_d = gap_q;
                            pv_d     = 1'b1;
                        end
                        edge_d  = edge_q + ONE;
                        gap_d   = ONE;
                        stall_d = 1'b0;
                        state_d = MEASURE;
                    end else if (gap_q == TIMEOUT_C) begin
                        stall_d = 1'b1;
                        gap_d   = '0;
                        state_d = ARM;
                    end else if (gap_q != GAP_MAX) begin
                        gap_d = gap_q + ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_period_monitor.sv
// Directed bench for div_period_monitor: a reset/start-up vector table,
// then hand-written sequences for period, stall, coincident timeout,
// enable drop, mid-measure reset and edge-count wrap.
module tb_div_period_monitor;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        div_in = 1'b0;

    logic        rp, pv, st;
    logic [15:0] period, edge_cnt;
    logic [1:0]  state;

    logic        rp4, pv4, st4;
    logic [3:0]  period4, edge4;
    logic [1:0]  state4;

    int errors = 0;
    int checks = 0;

    logic [3:0] exp_q[$];

    typedef struct {
        logic        rst;
        logic        en;
        logic        din;
        logic        rp;
        logic        pv;
        logic [15:0] per;
        logic [15:0] edg;
        logic        st;
        logic [1:0]  state;
    } vec_t;

    vec_t vecs[6];

    div_period_monitor #(.CNT_W(16), .TIMEOUT(20)) dut (
        .clk(clk), .reset(reset), .enable_i(enable), .div_in_i(div_in),
        .rise_pulse_o(rp), .period_o(period), .period_valid_o(pv),
        .edge_count_o(edge_cnt), .stall_o(st), .state_o(state)
    );

    div_period_monitor #(.CNT_W(4), .TIMEOUT(14)) dut4 (
        .clk(clk), .reset(reset), .enable_i(enable), .div_in_i(div_in),
        .rise_pulse_o(rp4), .period_o(period4), .period_valid_o(pv4),
        .edge_count_o(edge4), .stall_o(st4), .state_o(state4)
    );

    // Clock.
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic level, input int n, input logic exp_stall);
        div_in = level;
        repeat (n) begin
            cyc();
            chk("hold_rise_pulse", rp, 0);
            chk("hold_period_valid", pv, 0);
            chk("hold_stall", st, exp_stall);
        end
    endtask

    task automatic rise_cycle(input logic exp_pv, input logic [15:0] exp_period,
                              input logic [15:0] exp_edge);
        div_in = 1'b1;
        cyc();
        chk("rise_pulse", rp, 1);
        cyc();
        chk("rise_pulse_width", rp, 0);
        chk("period_valid", pv, exp_pv);
        chk("period", period, exp_period);
        chk("edge_count", edge_cnt, exp_edge);
        chk("stall_after_rise", st, 0);
    endtask

    initial begin
        // Reset with div_in toggling, then release and first rise.
        vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 2'd0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 2'd0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 2'd0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 2'd1};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 2'd1};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 16'd1, 1'b0, 2'd2};

        for (int i = 0; i < 6; i++) begin
            reset  = vecs[i].rst;
            enable = vecs[i].en;
            div_in = vecs[i].din;
            cyc();
            chk("vec_rise_pulse", rp, vecs[i].rp);
            chk("vec_period_valid", pv, vecs[i].pv);
            chk("vec_period", period, vecs[i].per);
            chk("vec_edge_count", edge_cnt, vecs[i].edg);
            chk("vec_stall", st, vecs[i].st);
            chk("vec_state", state, vecs[i].state);
        end

        // Basic period: high 5 / low 5, rises 2..6 report period 10.
        hold(1'b1, 3, 1'b0);
        hold(1'b0, 5, 1'b0);
        for (int i = 2; i <= 6; i++) begin
            rise_cycle(1'b1, 16'd10, 16'(i));
            if (i < 6) begin
                hold(1'b1, 3, 1'b0);
                hold(1'b0, 5, 1'b0);
            end
        end

        // Stall: exactly 21 cycles after the last rise_pulse.
        hold(1'b1, 3, 1'b0);
        hold(1'b0, 16, 1'b0);
        cyc();
        chk("stall_set", st, 1);
        chk("stall_state_arm", state, 1);
        hold(1'b0, 3, 1'b1);
        rise_cycle(1'b0, 16'd10, 16'd7);
        hold(1'b1, 3, 1'b0);
        hold(1'b0, 5, 1'b0);
        rise_cycle(1'b1, 16'd10, 16'd8);

        // Rises exactly TIMEOUT apart: rise wins, no stall.
        for (int i = 9; i <= 11; i++) begin
            hold(1'b1, 3, 1'b0);
            hold(1'b0, 15, 1'b0);
            rise_cycle(1'b1, 16'd20, 16'(i));
        end

        // Enable low for 4 cycles mid-measure, with a rise while disabled.
        hold(1'b1, 3, 1'b0);
        enable = 1'b0;
        div_in = 1'b0;
        cyc();
        chk("dis_state_idle", state, 0);
        chk("dis_period_held", period, 20);
        chk("dis_edge_held", edge_cnt, 11);
        chk("dis_stall", st, 0);
        cyc();
        div_in = 1'b1;
        cyc();
        chk("dis_rise_pulse_masked", rp, 0);
        cyc();
        chk("dis_edge_not_counted", edge_cnt, 11);
        chk("dis_period_valid", pv, 0);
        enable = 1'b1;
        cyc();
        chk("reen_state_arm", state, 1);
        chk("reen_rise_pulse", rp, 0);
        hold(1'b1, 2, 1'b0);
        hold(1'b0, 5, 1'b0);
        rise_cycle(1'b0, 16'd20, 16'd12);
        hold(1'b1, 3, 1'b0);
        hold(1'b0, 5, 1'b0);
        rise_cycle(1'b1, 16'd10, 16'd13);

        // enable dropped in the same cycle a rise is seen.
        hold(1'b1, 3, 1'b0);
        hold(1'b0, 5, 1'b0);
        div_in = 1'b1;
        cyc();
        chk("coinc_rise_pulse", rp, 1);
        enable = 1'b0;
        cyc();
        chk("coinc_edge_ignored", edge_cnt, 13);
        chk("coinc_no_period_valid", pv, 0);
        chk("coinc_period_held", period, 10);
        chk("coinc_state_idle", state, 0);
        enable = 1'b1;

        // Reset in the middle of a measurement.
        hold(1'b0, 2, 1'b0);
        rise_cycle(1'b0, 16'd10, 16'd14);
        hold(1'b1, 2, 1'b0);
        reset = 1'b0;
        cyc();
        chk("rst_period", period, 0);
        chk("rst_edge_count", edge_cnt, 0);
        chk("rst_period_valid", pv, 0);
        chk("rst_stall", st, 0);
        chk("rst_rise_pulse", rp, 0);
        chk("rst_state", state, 0);

        // Edge-count wrap on the 4-bit instance, period 6.
        reset  = 1'b1;
        div_in = 1'b0;
        cyc();
        for (int i = 1; i <= 17; i++) exp_q.push_back(4'(i % 16));
        for (int i = 1; i <= 17; i++) begin
            div_in = 1'b1;
            cyc();
            chk("wrap_rise_pulse", rp4, 1);
            cyc();
            chk("wrap_edge_count", edge4, exp_q.pop_front());
            if (i > 1) begin
                chk("wrap_period_valid", pv4, 1);
                chk("wrap_period", period4, 6);
            end
            cyc();
            div_in = 1'b0;
            repeat (3) cyc();
        end
        chk("wrap_stall", st4, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
